// File: rtl/half_adder_structural_cell.sv
// One-bit half adder built purely from gate primitives.
// Serves as the structural reference cell for each lane of the top level.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  xor g_sum   (s, a, b);
  and g_carry (c, a, b);

endmodule

// File: rtl/half_adder_structural.sv
// WIDTH independent half-adder lanes with a registered sum/carry bank.
// Results appear one clock after a/b are sampled; rst clears outputs asynchronously.
module half_adder_structural #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;

  // Lanes never chain: each cell sees only its own operand bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (sum_w[i]),
      .c (carry_w[i])
    );
  end

  always_comb begin
    s_d = sum_w;
    c_d = carry_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s = s_q;
  assign c = c_q;

endmodule

// File: tb/tb_half_adder_structural.sv
// Scoreboard bench for the registered half adder, four lanes wide.
module tb_half_adder_structural;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic [W-1:0] c;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {expected s, expected c}.
  logic [2*W-1:0] exp_q[$];

  half_adder_structural #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .s   (s),
    .c   (c)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [2*W-1:0] obs,
                           input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", tag, obs, exp);
    end
  endtask

  // Driver: apply operands, queue the expected result, compare after the edge.
  task automatic drive_step(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input string tag);
    logic [2*W-1:0] exp;
    a = av;
    b = bv;
    exp_q.push_back({av ^ bv, av & bv});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_empty_q"}, {s, c}, 'x);
    end else begin
      exp = exp_q.pop_front();
      check_val({tag, "_s"}, {{W{1'b0}}, s}, {{W{1'b0}}, exp[2*W-1:W]});
      check_val({tag, "_c"}, {{W{1'b0}}, c}, {{W{1'b0}}, exp[W-1:0]});
    end
    check_val({tag, "_s_and_c"}, {{W{1'b0}}, s & c}, '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   pat;
    rst = 1'b0;
    a   = '1;
    b   = '1;

    // Async reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_val("async_reset_no_edge", {s, c}, '0);

    // Reset held across an edge keeps outputs clear.
    @(posedge clk);
    #1;
    check_val("reset_held_edge", {s, c}, '0);

    // Release between edges; nothing changes until the next edge.
    #2 rst = 1'b0;
    #1;
    check_val("release_pre_edge", {s, c}, '0);
    drive_step('1, '1, "ones");

    // Before the capturing edge the old result must still be visible.
    a = '0;
    b = '1;
    #1;
    check_val("hold_until_edge", {s, c}, {{W{1'b0}}, {W{1'b1}}});

    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      drive_step({W{pat[1]}}, {W{pat[0]}}, $sformatf("sweep%0d", i));
    end

    // Reset mid-cycle with a=1, b=0 held.
    drive_step('1, '0, "pre_mid_rst");
    #2 rst = 1'b1;
    #1;
    check_val("mid_cycle_reset", {s, c}, '0);
    @(posedge clk);
    #1;
    check_val("mid_reset_held", {s, c}, '0);
    #2 rst = 1'b0;
    drive_step('1, '0, "after_mid_rst");

    // No inter-lane carry.
    drive_step(4'b1100, 4'b1010, "lanes");
    n_checks++;
    if ({s, c} !== {4'b0110, 4'b1000}) begin
      n_errors++;
      $display("FAIL lanes_const: got s=%b c=%b, required s=0110 c=1000", s, c);
    end

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      drive_step(ra, rb, "rand");
    end

    check_val("queue_drained", {{(2*W-1){1'b0}}, exp_q.size() != 0}, '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
